// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, grantee ids and access opcode.
package mem_arbiter_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  typedef enum logic [1:0] {GNT_IF, GNT_LSU_R, GNT_LSU_W} grantee_e;

  typedef enum logic {OP_READ, OP_WRITE} opcode_e;

  function automatic opcode_e grant_op(input grantee_e g);
    return (g == GNT_LSU_W) ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Three-requester (fetch, LSU read, LSU write) arbiter onto a single memory port.
// Handshake: requests are levels held until the matching one-cycle ack; o_mem_req is held with stable fields until i_mem_ack or timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int STARVE  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_if_read,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_data,
  output logic          o_if_ack,
  input  logic          i_lsu_read,
  input  logic [AW-1:0] i_r_lsu_addr,
  output logic [DW-1:0] o_r_lsu_data,
  output logic          o_lsu_r_ack,
  input  logic          i_lsu_write,
  input  logic [AW-1:0] i_w_lsu_addr,
  input  logic [3:0]    i_w_lsu_byte_en,
  input  logic [DW-1:0] i_w_lsu_data,
  output logic          o_lsu_w_ack,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_byte_en,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_timeout,
  output state_e        o_dbg_state
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE + 1);

  state_e        r_state;
  grantee_e      r_gnt;
  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [3:0]    r_mem_be;
  logic [DW-1:0] r_mem_wdata, r_if_data, r_lsu_data;
  logic          r_if_ack, r_lsu_r_ack, r_lsu_w_ack, r_timeout;
  logic [WW-1:0] r_wait;
  logic [SW-1:0] r_starve;

  grantee_e      w_gnt;
  logic          w_is_wr, w_any_req, w_ack_busy, w_expire;

  always_comb begin
    w_gnt = GNT_IF;
    if (i_if_read && (r_starve == SW'(STARVE))) w_gnt = GNT_IF;
    else if (i_lsu_write)                       w_gnt = GNT_LSU_W;
    else if (i_lsu_read)                        w_gnt = GNT_LSU_R;
    w_is_wr   = (grant_op(w_gnt) == OP_WRITE);
    w_any_req = i_if_read | i_lsu_read | i_lsu_write;
    // Requesters still see their ack this cycle, so their level is stale: hold off one cycle.
    w_ack_busy = r_if_ack | r_lsu_r_ack | r_lsu_w_ack;
    w_expire   = (r_wait == WW'(TIMEOUT - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= GNT_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_lsu_data  <= '0;
      r_if_ack    <= 1'b0;
      r_lsu_r_ack <= 1'b0;
      r_lsu_w_ack <= 1'b0;
      r_timeout   <= 1'b0;
      r_wait      <= '0;
      r_starve    <= '0;
    end else if (i_clk_en) begin
      r_if_ack    <= 1'b0;
      r_lsu_r_ack <= 1'b0;
      r_lsu_w_ack <= 1'b0;
      r_timeout   <= 1'b0;
      if (!i_if_read) r_starve <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req && !w_ack_busy) begin
            r_gnt       <= w_gnt;
            r_state     <= ST_BUSY;
            r_mem_req   <= 1'b1;
            r_wait      <= '0;
            r_mem_we    <= w_is_wr;
            r_mem_be    <= w_is_wr ? i_w_lsu_byte_en : 4'hF;
            r_mem_wdata <= w_is_wr ? i_w_lsu_data : '0;
            case (w_gnt)
              GNT_LSU_W: r_mem_addr <= i_w_lsu_addr;
              GNT_LSU_R: r_mem_addr <= i_r_lsu_addr;
              default:   r_mem_addr <= i_if_addr;
            endcase
            if (w_gnt == GNT_IF)                           r_starve <= '0;
            else if (i_if_read && r_starve != SW'(STARVE)) r_starve <= r_starve + 1'b1;
          end
        end
        ST_BUSY: begin
          if (i_mem_ack || w_expire) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_timeout <= !i_mem_ack;
            case (r_gnt)
              GNT_IF: begin
                r_if_ack  <= 1'b1;
                r_if_data <= i_mem_ack ? i_mem_rdata : '0;
              end
              GNT_LSU_R: begin
                r_lsu_r_ack <= 1'b1;
                r_lsu_data  <= i_mem_ack ? i_mem_rdata : '0;
              end
              default: r_lsu_w_ack <= 1'b1;
            endcase
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_if_data     = r_if_data;
  assign o_if_ack      = r_if_ack;
  assign o_r_lsu_data  = r_lsu_data;
  assign o_lsu_r_ack   = r_lsu_r_ack;
  assign o_lsu_w_ack   = r_lsu_w_ack;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_byte_en = r_mem_be;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_timeout     = r_timeout;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a grant-order model fills exp_q, a negedge monitor pops on each ack.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TMO = 4;
  localparam int STV = 8;

  typedef struct packed {
    logic [1:0]  gnt;   // 0 fetch, 1 lsu read, 2 lsu write
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst, clk_en;
  logic if_read, lsu_read, lsu_write;
  logic [31:0] if_addr, r_addr, w_addr, w_data;
  logic [3:0] w_be;
  logic [31:0] if_data, lsu_data, mem_addr, mem_wdata, mem_rdata;
  logic if_ack, lsu_r_ack, lsu_w_ack, mem_req, mem_we, mem_ack, timeout;
  logic [3:0] mem_be;
  state_e dbg_state;
  logic model_ack, test_ack;
  int mem_mode, mem_fix;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] f_q[$], r_q[$], w_a_q[$], w_d_q[$];
  logic [3:0] w_b_q[$];
  logic [31:0] mdl_if, mdl_lr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_data(mem_addr);
  assign mem_ack = model_ack | test_ack;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .STARVE(STV)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_if_read(if_read), .i_if_addr(if_addr), .o_if_data(if_data), .o_if_ack(if_ack),
    .i_lsu_read(lsu_read), .i_r_lsu_addr(r_addr), .o_r_lsu_data(lsu_data), .o_lsu_r_ack(lsu_r_ack),
    .i_lsu_write(lsu_write), .i_w_lsu_addr(w_addr), .i_w_lsu_byte_en(w_be),
    .i_w_lsu_data(w_data), .o_lsu_w_ack(lsu_w_ack),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_byte_en(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_timeout(timeout), .o_dbg_state(dbg_state)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---- memory model: mode 0 acks after a delay, mode 1 never acks on its own ----
  initial begin
    logic en_q, armed;
    int dly;
    model_ack = 1'b0;
    armed = 1'b0;
    dly = 0;
    forever begin
      @(posedge clk);
      en_q = clk_en && !rst;
      #1;
      if (model_ack && en_q) begin model_ack = 1'b0; armed = 1'b0; end
      if (!mem_req) armed = 1'b0;
      else if (!armed && !model_ack) begin
        armed = 1'b1;
        dly = (mem_fix >= 0) ? mem_fix : int'($urandom_range(0, 2));
      end
      if (armed && !model_ack && mem_mode == 0) begin
        if (dly == 0) model_ack = 1'b1;
        else dly--;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int g, input logic [31:0] a, input logic [3:0] be,
                                   input logic [31:0] d, input logic to);
    exp_t e;
    e.gnt   = 2'(g);
    e.we    = (g == 2);
    e.addr  = a;
    e.be    = (g == 2) ? be : 4'hF;
    e.wdata = (g == 2) ? d : 32'h0;
    e.rdata = (to || g == 2) ? 32'h0 : mem_data(a);
    e.to    = to;
    exp_q.push_back(EW'(e));
  endfunction

  // ---- scoreboard monitor ----
  task automatic monitor_loop();
    exp_t e;
    logic [2:0] acks;
    forever begin
      @(negedge clk);
      if (rst) begin mdl_if = '0; mdl_lr = '0; end
      acks = {lsu_w_ack, lsu_r_ack, if_ack};
      if (mem_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req actual=addr %0h expected=no request", mem_addr);
        end else begin
          e = exp_t'(exp_q[0]);
          if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be ||
              (e.we && mem_wdata !== e.wdata)) begin
            failures++;
            $display("FAIL mem_fields actual=we%0b a%0h be%0h d%0h expected=we%0b a%0h be%0h d%0h",
                     mem_we, mem_addr, mem_be, mem_wdata, e.we, e.addr, e.be, e.wdata);
          end
        end
      end
      if (acks != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack actual=%b expected=000", acks);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("ack_id", {acks, timeout}, {3'b001 << e.gnt, e.to});
          if (e.gnt == 2'd0) begin check("if_rdata", if_data, e.rdata); mdl_if = e.rdata; end
          if (e.gnt == 2'd1) begin check("lsu_rdata", lsu_data, e.rdata); mdl_lr = e.rdata; end
        end
      end else begin
        check("stray_timeout", timeout, 1'b0);
      end
      check("rdata_hold", {if_data, lsu_data}, {mdl_if, mdl_lr});
    end
  endtask

  // ---- requester driver: holds a level per transaction until its ack ----
  task automatic drive(input int port);
    int n;
    logic got;
    n = (port == 0) ? f_q.size() : (port == 1) ? r_q.size() : w_a_q.size();
    for (int k = 0; k < n; k++) begin
      case (port)
        0: begin if_addr = f_q[k]; if_read = 1'b1; end
        1: begin r_addr = r_q[k]; lsu_read = 1'b1; end
        default: begin
          w_addr = w_a_q[k]; w_be = w_b_q[k]; w_data = w_d_q[k]; lsu_write = 1'b1;
        end
      endcase
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        got = (port == 0) ? if_ack : (port == 1) ? lsu_r_ack : lsu_w_ack;
      end
      check("ack_arrives", got, 1'b1);
      @(posedge clk); #1;
      if (!got) break;
    end
    case (port)
      0: if_read = 1'b0;
      1: lsu_read = 1'b0;
      default: lsu_write = 1'b0;
    endcase
  endtask

  task automatic clear_q();
    f_q.delete(); r_q.delete(); w_a_q.delete(); w_d_q.delete(); w_b_q.delete();
  endtask

  task automatic gen_rand(input int nf, input int nr, input int nw);
    clear_q();
    for (int i = 0; i < nf; i++) f_q.push_back($urandom);
    for (int i = 0; i < nr; i++) r_q.push_back($urandom);
    for (int i = 0; i < nw; i++) begin
      w_a_q.push_back($urandom);
      w_d_q.push_back($urandom);
      w_b_q.push_back(4'($urandom_range(0, 15)));
    end
  endtask

  // Grant order from the rules: a starved fetch first, then write > read > fetch.
  task automatic run_batch(input int fix);
    int s, cf, cr, cw, nf, nr, nw;
    mem_mode = 0;
    mem_fix = fix;
    nf = f_q.size(); nr = r_q.size(); nw = w_a_q.size();
    s = 0; cf = 0; cr = 0; cw = 0;
    while (cf < nf || cr < nr || cw < nw) begin
      if (cf < nf && s == STV) begin
        push_exp(0, f_q[cf], 4'h0, 32'h0, 1'b0); cf++; s = 0;
      end else if (cw < nw || cr < nr) begin
        if (cw < nw) begin push_exp(2, w_a_q[cw], w_b_q[cw], w_d_q[cw], 1'b0); cw++; end
        else begin push_exp(1, r_q[cr], 4'h0, 32'h0, 1'b0); cr++; end
        s = (cf < nf) ? ((s < STV) ? s + 1 : STV) : 0;
      end else begin
        push_exp(0, f_q[cf], 4'h0, 32'h0, 1'b0); cf++; s = 0;
      end
    end
    fork
      drive(0);
      drive(1);
      drive(2);
    join
    repeat (2) @(posedge clk);
    #1;
    check("batch_drained", exp_q.size(), 0);
    check("batch_idle", dbg_state, ST_IDLE);
    exp_q.delete();
  endtask

  task automatic wait_mem_req();
    for (int c = 0; c < 50 && !mem_req; c++) @(negedge clk);
    check("mem_req_rises", mem_req, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---- main sequence ----
  initial begin
    int cnt;
    rst = 1'b1; clk_en = 1'b1; test_ack = 1'b0; mem_mode = 0; mem_fix = -1;
    if_read = 0; lsu_read = 0; lsu_write = 0;
    if_addr = '0; r_addr = '0; w_addr = '0; w_data = '0; w_be = '0;
    mdl_if = '0; mdl_lr = '0;
    fork monitor_loop(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_be}, 0);
    check("rst_acks", {if_ack, lsu_r_ack, lsu_w_ack, timeout}, 0);
    check("rst_data", {if_data, lsu_data}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single write, ack on the third busy cycle
    clear_q();
    w_a_q.push_back(32'h100); w_b_q.push_back(4'b0011); w_d_q.push_back(32'hDEADBEEF);
    run_batch(2);

    // all three at once, immediate ack
    gen_rand(1, 1, 1);
    run_batch(0);

    // continuous read plus fetch: fetch forced in on the 9th grant
    gen_rand(2, 18, 0);
    run_batch(0);

    // random mixes and latencies
    for (int i = 0; i < 10; i++) begin
      gen_rand($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_batch(-1);
    end

    // timeout: memory never answers
    mem_mode = 1;
    clear_q();
    push_exp(1, 32'h0000_2468, 4'h0, 32'h0, 1'b1);
    r_addr = 32'h0000_2468; lsu_read = 1'b1;
    for (int c = 0; c < 50 && !mem_req; c++) @(negedge clk);
    cnt = 0;
    while (mem_req && cnt < 50) begin cnt++; @(negedge clk); end
    check("timeout_busy_cycles", cnt, TMO);
    check("timeout_pulse", {lsu_r_ack, timeout}, 2'b11);
    @(posedge clk); #1;
    lsu_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("timeout_drained", exp_q.size(), 0);

    // clock enable low while memory acks: nothing moves
    push_exp(1, 32'h0000_0ABC, 4'h0, 32'h0, 1'b0);
    r_addr = 32'h0000_0ABC; lsu_read = 1'b1;
    wait_mem_req();
    clk_en = 1'b0; test_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("clken_hold", {mem_req, lsu_r_ack, dbg_state}, {2'b10, ST_BUSY});
    end
    @(posedge clk); #1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    test_ack = 1'b0;
    @(negedge clk);
    check("clken_ack", {lsu_r_ack, lsu_data}, {1'b1, mem_data(32'h0000_0ABC)});
    @(posedge clk); #1;
    lsu_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("clken_drained", exp_q.size(), 0);

    // reset in the middle of a write, then a late ack
    push_exp(2, 32'h0000_0F00, 4'hC, 32'h1234_5678, 1'b0);
    w_addr = 32'h0000_0F00; w_be = 4'hC; w_data = 32'h1234_5678; lsu_write = 1'b1;
    wait_mem_req();
    rst = 1'b1;
    #1;
    check("midrst_mem", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 0);
    check("midrst_acks", {if_ack, lsu_r_ack, lsu_w_ack, timeout}, 0);
    check("midrst_data", {if_data, lsu_data}, 0);
    exp_q.delete();
    lsu_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    test_ack = 1'b1;
    @(posedge clk); #1;
    test_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_ack_ignored", {mem_req, if_ack, lsu_r_ack, lsu_w_ack, dbg_state}, {4'b0000, ST_IDLE});
    end

    // arbiter still works afterwards
    gen_rand(1, 1, 1);
    run_batch(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
